// File: rtl/mixsys_pkg.sv
// mixsys_pkg: shared PRNG byte type and a constant clog2 helper
package mixsys_pkg;
  localparam int PRNG_BYTE_W = 8;
  typedef logic [PRNG_BYTE_W-1:0] prng_byte_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/prng_sync_fifo.sv
// prng_sync_fifo: first-word-fall-through FIFO with wrap-bit pointers
module prng_sync_fifo
  import mixsys_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int LW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_empty,
  output logic [LW-1:0]    o_level
);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wp, r_rp;
  logic [WIDTH-1:0] r_last;
  logic             w_pop, w_push;
  assign o_level = r_wp - r_rp;
  assign o_full  = o_level == LW'(DEPTH);
  assign o_empty = r_wp == r_rp;
  assign w_pop   = i_pop & ~o_empty;
  assign w_push  = i_push & (~o_full | w_pop);
  // the head register keeps the last shown word once the FIFO drains
  assign o_data  = o_empty ? r_last : r_mem[r_rp[AW-1:0]];
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= i_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_wp   <= '0;
      r_rp   <= '0;
      r_last <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) begin
        r_rp   <= r_rp + 1'b1;
        r_last <= o_data;
      end
    end
endmodule

// File: rtl/prng_word_packer.sv
// prng_word_packer: packs PRNG bytes into words behind a repetition-count health test
module prng_word_packer
  import mixsys_pkg::*;
#(
  parameter int BYTES     = 4,
  parameter int DEPTH     = 4,
  parameter int REP_LIMIT = 16,
  parameter int CNT_W     = 8,
  localparam int OUT_W = PRNG_BYTE_W * BYTES,
  localparam int IW    = clog2(BYTES) > 0 ? clog2(BYTES) : 1,
  localparam int LW    = clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  prng_byte_t       in_data,
  input  logic             clr_stuck,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic [LW-1:0]    level,
  output logic             stuck,
  output logic [CNT_W-1:0] drop_cnt
);
  logic [IW-1:0]    r_idx;
  logic [OUT_W-1:0] r_word, w_word;
  prng_byte_t       r_prev;
  logic             r_prev_v, r_stuck;
  logic [7:0]       r_rep, w_rep_nx;
  logic [CNT_W-1:0] r_drop;
  logic             w_acc, w_trip, w_take, w_last, w_push, w_pop, w_full, w_empty;
  assign w_acc    = in_valid & ~r_stuck & ~clr_stuck;
  assign w_rep_nx = (r_prev_v && in_data == r_prev) ? r_rep + 8'd1 : 8'd1;
  assign w_trip   = w_acc && w_rep_nx == 8'(REP_LIMIT);
  assign w_take   = w_acc & ~w_trip;
  assign w_last   = r_idx == IW'(BYTES - 1);
  assign w_push   = w_take & w_last;
  assign w_pop    = out_valid & out_ready;
  assign out_valid = ~w_empty;
  assign stuck    = r_stuck;
  assign drop_cnt = r_drop;
  always_comb begin
    w_word = r_word;
    w_word[PRNG_BYTE_W*r_idx +: PRNG_BYTE_W] = in_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_idx    <= '0;
      r_word   <= '0;
      r_prev   <= '0;
      r_prev_v <= 1'b0;
      r_stuck  <= 1'b0;
      r_rep    <= '0;
    end else if (clr_stuck) begin
      r_stuck  <= 1'b0;
      r_rep    <= '0;
      r_prev_v <= 1'b0;
      r_idx    <= '0;
    end else if (w_trip) begin
      r_stuck <= 1'b1;
      r_idx   <= '0;
    end else if (w_take) begin
      r_word   <= w_word;
      r_idx    <= w_last ? '0 : r_idx + 1'b1;
      r_rep    <= w_rep_nx;
      r_prev   <= in_data;
      r_prev_v <= 1'b1;
    end
  // a push into a full FIFO is only lost when the head is not leaving the same cycle
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_drop <= '0;
    else if (w_push & w_full & ~w_pop & ~&r_drop) r_drop <= r_drop + 1'b1;
  prng_sync_fifo #(.WIDTH(OUT_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_data  (w_word),
    .i_pop   (out_ready),
    .o_data  (out_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (level)
  );
endmodule
